cc_condition_code_unit: RTL



---
 rtl/cc_condition_code_unit_pkg.sv | 41 ++++
 rtl/cc_condition_code_unit_if.sv | 48 ++++
 rtl/cc_condition_code_unit_branch_cond_eval.sv | 37 +++
 rtl/cc_condition_code_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/cc_condition_code_unit_pkg.sv
// cc_ccunit_pkg
// Shared definitions for the condition-code unit:
//   - SPARC-style branch condition encodings (COND_BN .. COND_BVC)
//   - FSM state encoding for the evaluation handshake
//   - bit positions of the flags inside the PSR nibble {N,Z,V,C}
package cc_ccunit_pkg;

  localparam int COND_W = 4;
  localparam int PSR_W  = 4;

  // PSR bit positions (flags are active high inside the PSR)
  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;

  // Branch conditions. Bit 3 inverts the base condition picked by bits 2:0.
  localparam logic [3:0] COND_BN   = 4'b0000;
  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BLE  = 4'b0010;
  localparam logic [3:0] COND_BL   = 4'b0011;
  localparam logic [3:0] COND_BLEU = 4'b0100;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;
  localparam logic [3:0] COND_BNE  = 4'b1001;
  localparam logic [3:0] COND_BG   = 4'b1010;
  localparam logic [3:0] COND_BGE  = 4'b1011;
  localparam logic [3:0] COND_BGU  = 4'b1100;
  localparam logic [3:0] COND_BCC  = 4'b1101;
  localparam logic [3:0] COND_BPOS = 4'b1110;
  localparam logic [3:0] COND_BVC  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EVAL   = 2'b01,
    RESULT = 2'b10
  } state_t;

endpackage

// File: rtl/cc_condition_code_unit_if.sv
// cc_condition_code_unit_if
// Bundles the ALU flag inputs, the setcc strobe, the request/valid/ack
// handshake and the registered outputs of the condition-code unit.
//   master : control unit / ALU side (drives flags, setcc, cond, req, ack)
//   slave  : the condition-code unit (drives psr, valid, taken, busy, dbg_state)
//
// Handshake: the master raises req with cond while the unit is IDLE. The unit
// raises valid with taken two edges after req is sampled and holds both stable
// until the master asserts ack. ack together with req starts the next
// evaluation immediately; req without ack is ignored outside IDLE (no queue).
interface cc_condition_code_unit_if #(
  parameter int DATAWIDTH_COND = 4,
  parameter int DATAWIDTH_PSR  = 4
);
  import cc_ccunit_pkg::*;

  logic                      CC_CCUNIT_negative_InLow;
  logic                      CC_CCUNIT_zero_InLow;
  logic                      CC_CCUNIT_overflow_InLow;
  logic                      CC_CCUNIT_carry_InLow;
  logic                      CC_CCUNIT_setcc_In;
  logic [DATAWIDTH_COND-1:0] CC_CCUNIT_cond_InBUS;
  logic                      CC_CCUNIT_req_In;
  logic                      CC_CCUNIT_ack_In;
  logic [DATAWIDTH_PSR-1:0]  CC_CCUNIT_psr_OutBUS;
  logic                      CC_CCUNIT_valid_Out;
  logic                      CC_CCUNIT_taken_Out;
  logic                      CC_CCUNIT_busy_Out;
  state_t                    dbg_state;

  modport master (
    output CC_CCUNIT_negative_InLow, CC_CCUNIT_zero_InLow,
           CC_CCUNIT_overflow_InLow, CC_CCUNIT_carry_InLow,
           CC_CCUNIT_setcc_In, CC_CCUNIT_cond_InBUS,
           CC_CCUNIT_req_In, CC_CCUNIT_ack_In,
    input  CC_CCUNIT_psr_OutBUS, CC_CCUNIT_valid_Out,
           CC_CCUNIT_taken_Out, CC_CCUNIT_busy_Out, dbg_state
  );

  modport slave (
    input  CC_CCUNIT_negative_InLow, CC_CCUNIT_zero_InLow,
           CC_CCUNIT_overflow_InLow, CC_CCUNIT_carry_InLow,
           CC_CCUNIT_setcc_In, CC_CCUNIT_cond_InBUS,
           CC_CCUNIT_req_In, CC_CCUNIT_ack_In,
    output CC_CCUNIT_psr_OutBUS, CC_CCUNIT_valid_Out,
           CC_CCUNIT_taken_Out, CC_CCUNIT_busy_Out, dbg_state
  );
endinterface

// File: rtl/cc_condition_code_unit_branch_cond_eval.sv
// cc_branch_cond_eval
// Combinational branch-condition evaluator.
//   cond  [3:0] : branch condition; bit 3 inverts the base condition of bits 2:0
//   flags [3:0] : {N,Z,V,C}, active high
//   taken       : branch taken
module cc_branch_cond_eval
  import cc_ccunit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);
  logic n, z, v, c;
  logic base;

  assign n = flags[PSR_N];
  assign z = flags[PSR_Z];
  assign v = flags[PSR_V];
  assign c = flags[PSR_C];

  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      3'b000:  base = 1'b0;           // never (inverted: always)
      3'b001:  base = z;
      3'b010:  base = z | (n ^ v);
      3'b011:  base = n ^ v;
      3'b100:  base = c | z;
      3'b101:  base = c;
      3'b110:  base = n;
      3'b111:  base = v;
      default: base = 1'b0;
    endcase
  end

  assign taken = base ^ cond[3];
endmodule

// File: rtl/cc_condition_code_unit.sv
// cc_condition_code_unit
// Latches the ALU's active-low N/Z/V/C flags into an active-high PSR on setcc
// and evaluates a branch condition against it through a req/valid/ack handshake.
// Ports:
//   CC_CCUNIT_CLOCK_50     : clock, rising edge
//   CC_CCUNIT_RESET_InHigh : synchronous reset, active high
//   bus (slave)            : flags, setcc, cond, req, ack in;
//                            psr, valid, taken, busy, dbg_state out
module cc_condition_code_unit
  import cc_ccunit_pkg::*;
#(
  parameter int DATAWIDTH_COND = 4,
  parameter int DATAWIDTH_PSR  = 4
) (
  input  logic                   CC_CCUNIT_CLOCK_50,
  input  logic                   CC_CCUNIT_RESET_InHigh,
  cc_condition_code_unit_if.slave bus
);
  logic                      clk, rst;
  logic [DATAWIDTH_PSR-1:0]  psr_q;
  logic [DATAWIDTH_PSR-1:0]  new_flags;
  logic [DATAWIDTH_PSR-1:0]  eff_flags;
  logic [DATAWIDTH_COND-1:0] cond_q, cond_d;
  logic                      taken_q, taken_d, taken_w;
  state_t                    state_q, state_d;

  assign clk = CC_CCUNIT_CLOCK_50;
  assign rst = CC_CCUNIT_RESET_InHigh;

  assign new_flags = ~{bus.CC_CCUNIT_negative_InLow, bus.CC_CCUNIT_zero_InLow,
                       bus.CC_CCUNIT_overflow_InLow, bus.CC_CCUNIT_carry_InLow};

  // PSR runs independently of the FSM
  always_ff @(posedge clk) begin
    if (rst)                         psr_q <= '0;
    else if (bus.CC_CCUNIT_setcc_In) psr_q <= new_flags;
  end

  // Bypass: a setcc in the same cycle as EVAL is seen by the evaluation
  assign eff_flags = bus.CC_CCUNIT_setcc_In ? new_flags : psr_q;

  cc_branch_cond_eval u_eval (
    .cond  (cond_q),
    .flags (eff_flags),
    .taken (taken_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cond_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    taken_d = taken_q;
    case (state_q)
      IDLE: begin
        if (bus.CC_CCUNIT_req_In) begin
          cond_d  = bus.CC_CCUNIT_cond_InBUS;
          state_d = EVAL;
        end
      end
      EVAL: begin
        taken_d = taken_w;
        state_d = RESULT;
      end
      RESULT: begin
        if (bus.CC_CCUNIT_ack_In) begin
          if (bus.CC_CCUNIT_req_In) begin
            cond_d  = bus.CC_CCUNIT_cond_InBUS;
            state_d = EVAL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs come straight from flops (state decode only, no input paths)
  assign bus.CC_CCUNIT_psr_OutBUS = psr_q;
  assign bus.CC_CCUNIT_valid_Out  = (state_q == RESULT);
  assign bus.CC_CCUNIT_taken_Out  = taken_q;
  assign bus.CC_CCUNIT_busy_Out   = (state_q != IDLE);
  assign bus.dbg_state            = state_q;
endmodule
